// File: rtl/aes_mode_datapath.sv
// AES encryption mode datapath: chaining and counter registers,
// core input selection and registered ciphertext for ECB/CBC/CFB/OFB/CTR.
module aes_mode_datapath #(
    parameter int CTR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [2:0]   mode,
    input  logic [127:0] plaintext,
    input  logic [127:0] iv,
    input  logic [127:0] aes_out,
    input  logic         fb_load_iv,
    input  logic         fb_update,
    input  logic         ctr_load,
    input  logic         ctr_inc,
    input  logic         data_valid,
    output logic [127:0] aes_in,
    output logic [127:0] result,
    output logic         result_valid,
    output logic [31:0]  block_count
);

    localparam logic [2:0] MODE_ECB = 3'd0;
    localparam logic [2:0] MODE_CBC = 3'd1;
    localparam logic [2:0] MODE_CFB = 3'd2;
    localparam logic [2:0] MODE_OFB = 3'd3;
    localparam logic [2:0] MODE_CTR = 3'd4;

    // Only the low CTR_WIDTH bits count; the rest is a fixed nonce.
    localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_WIDTH);

    logic [127:0] fb_reg;
    logic [127:0] ctr_reg;
    logic [127:0] ct;
    logic [127:0] ctr_next;
    logic [127:0] ctr_sum;
    logic         fb_applies;

    always_comb begin
        aes_in = plaintext;
        unique case (mode)
            MODE_CBC: aes_in = plaintext ^ fb_reg;
            MODE_CFB: aes_in = fb_reg;
            MODE_OFB: aes_in = fb_reg;
            MODE_CTR: aes_in = ctr_reg;
            default:  aes_in = plaintext;
        endcase
    end

    always_comb begin
        ct = aes_out;
        unique case (mode)
            MODE_CFB: ct = aes_out ^ plaintext;
            MODE_OFB: ct = aes_out ^ plaintext;
            MODE_CTR: ct = aes_out ^ plaintext;
            default:  ct = aes_out;
        endcase
    end

    assign fb_applies = (mode == MODE_CBC) || (mode == MODE_CFB) ||
                        (mode == MODE_OFB);
    assign ctr_sum    = ctr_reg + 128'd1;
    assign ctr_next   = (ctr_reg & ~CTR_MASK) | (ctr_sum & CTR_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            fb_reg       <= '0;
            ctr_reg      <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            block_count  <= '0;
        end else begin
            if (fb_load_iv) begin
                fb_reg <= iv;
            end else if (fb_update && fb_applies) begin
                // OFB chains on the raw keystream, CBC/CFB on ciphertext.
                fb_reg <= (mode == MODE_OFB) ? aes_out : ct;
            end

            if (ctr_load) begin
                ctr_reg <= iv;
            end else if (ctr_inc && mode == MODE_CTR) begin
                ctr_reg <= ctr_next;
            end

            result_valid <= data_valid;
            if (data_valid) begin
                result <= ct;
            end

            if (fb_load_iv || ctr_load) begin
                block_count <= data_valid ? 32'd1 : 32'd0;
            end else if (data_valid) begin
                block_count <= block_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_mode_datapath.sv
// Directed bench for aes_mode_datapath; the internal chaining and
// counter registers are observed through aes_in in CFB/CTR mode.
module tb_aes_mode_datapath;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   mode;
    logic [127:0] plaintext;
    logic [127:0] iv;
    logic [127:0] aes_out;
    logic         fb_load_iv;
    logic         fb_update;
    logic         ctr_load;
    logic         ctr_inc;
    logic         data_valid;
    logic [127:0] aes_in;
    logic [127:0] result;
    logic         result_valid;
    logic [31:0]  block_count;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AO    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] IV0   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AO2   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] NIB0F = {32{4'hf}} & {16{8'h0f}};
    localparam logic [127:0] NIBF0 = {16{8'hf0}};
    localparam logic [127:0] CIV   = 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_ffffffff;
    localparam logic [127:0] KX    = 128'hdeadbeef_01234567_89abcdef_cafef00d;

    always #5 clk = ~clk;

    aes_mode_datapath #(.CTR_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .mode         (mode),
        .plaintext    (plaintext),
        .iv           (iv),
        .aes_out      (aes_out),
        .fb_load_iv   (fb_load_iv),
        .fb_update    (fb_update),
        .ctr_load     (ctr_load),
        .ctr_inc      (ctr_inc),
        .data_valid   (data_valid),
        .aes_in       (aes_in),
        .result       (result),
        .result_valid (result_valid),
        .block_count  (block_count)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fb_load_iv = 0; fb_update = 0;
        ctr_load = 0; ctr_inc = 0; data_valid = 0;
    endtask

    initial begin
        reset = 1; mode = 0; plaintext = PT; iv = '0; aes_out = '0;
        idle();
        tick(); tick();
        reset = 0;
        check("rst_result", result, '0);
        check("rst_valid", {127'd0, result_valid}, 128'd0);
        check("rst_count", {96'd0, block_count}, 128'd0);
        mode = 3; #1 check("rst_fb", aes_in, '0);
        mode = 4; #1 check("rst_ctr", aes_in, '0);

        // ECB
        mode = 0; plaintext = PT; aes_out = AO; #1;
        check("ecb_aes_in", aes_in, PT);
        data_valid = 1; tick(); idle();
        check("ecb_result", result, AO);
        check("ecb_valid", {127'd0, result_valid}, 128'd1);
        check("ecb_count", {96'd0, block_count}, 128'd1);
        tick();
        check("ecb_valid_drop", {127'd0, result_valid}, 128'd0);
        check("ecb_hold", result, AO);

        // CBC
        mode = 1; iv = IV0; fb_load_iv = 1; tick(); idle();
        check("cbc_count_clr", {96'd0, block_count}, 128'd0);
        check("cbc_aes_in", aes_in,
              128'h00102030405060708090a0b0c0d0e0f0);
        aes_out = AO2; data_valid = 1; fb_update = 1; tick(); idle();
        check("cbc_result", result, AO2);
        check("cbc_count", {96'd0, block_count}, 128'd1);
        mode = 2; #1 check("cbc_fb", aes_in, AO2);

        // CFB
        mode = 2; iv = ONES; plaintext = NIBF0; aes_out = NIB0F;
        fb_load_iv = 1; tick(); idle();
        data_valid = 1; fb_update = 1; tick(); idle();
        check("cfb_result", result, ONES);
        check("cfb_fb", aes_in, ONES);

        // OFB
        mode = 3; iv = '0; fb_load_iv = 1; tick(); idle();
        data_valid = 1; fb_update = 1; tick(); idle();
        check("ofb_result", result, ONES);
        check("ofb_fb", aes_in, NIB0F);

        // CTR wrap without carry into the nonce
        mode = 4; iv = CIV; plaintext = PT; aes_out = AO;
        ctr_load = 1; tick(); idle();
        check("ctr_load", aes_in, CIV);
        ctr_inc = 1; data_valid = 1; tick(); idle();
        check("ctr_wrap", aes_in, 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_00000000);
        check("ctr_count", {96'd0, block_count}, 128'd1);
        check("ctr_result", result, AO ^ PT);
        ctr_inc = 1; tick(); idle();
        check("ctr_inc2", aes_in, 128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_00000001);

        // ctr_inc outside CTR mode is ignored
        mode = 1; ctr_inc = 1; tick(); idle();
        mode = 4; #1 check("ctr_ignore", aes_in,
                           128'ha5a5a5a5_a5a5a5a5_a5a5a5a5_00000001);

        // Priorities
        mode = 1; iv = KX; aes_out = AO2;
        fb_load_iv = 1; fb_update = 1; tick(); idle();
        mode = 2; #1 check("fb_prio", aes_in, KX);
        mode = 4; iv = IV0; ctr_load = 1; ctr_inc = 1; tick(); idle();
        check("ctr_prio", aes_in, IV0);
        ctr_load = 1; data_valid = 1; tick(); idle();
        check("load_dv_count", {96'd0, block_count}, 128'd1);

        // Reserved mode 6 acts as ECB; fb_update ignored
        mode = 1; iv = KX; fb_load_iv = 1; tick(); idle();
        mode = 6; plaintext = PT; aes_out = AO; #1;
        check("rsv_aes_in", aes_in, PT);
        data_valid = 1; fb_update = 1; tick(); idle();
        check("rsv_result", result, AO);
        mode = 2; #1 check("rsv_fb", aes_in, KX);

        // Reset in the data_valid cycle
        mode = 4; iv = CIV; ctr_load = 1; tick(); idle();
        mode = 0; data_valid = 1; fb_update = 1; reset = 1;
        tick(); idle(); reset = 0;
        check("mid_rst_result", result, '0);
        check("mid_rst_valid", {127'd0, result_valid}, 128'd0);
        check("mid_rst_count", {96'd0, block_count}, 128'd0);
        mode = 2; #1 check("mid_rst_fb", aes_in, '0);
        mode = 4; #1 check("mid_rst_ctr", aes_in, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
